spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command sequencer behind the SPI byte slave. Parses each SS-framed byte stream as a command byte followed by data bytes, turning them into reads and writes on a simple register bus with address auto-increment. It also drives the byte slave's transmit byte: a status byte during the command slot, read data during the slots after that. Sits between the SPI byte slave and the user register file, in the sysClk domain.

## Interface
- ID, 7'h2A: constant in status byte bits [6:0].
- ACK_TIMEOUT, 255: max sysClk cycles a bus request waits for regAck (1..65535).
- sysClk  in  1  system clock; all logic on rising edge.
- usrReset  in  1  reset, asynchronous, active-high.
- SS  in  1  raw SPI slave select, active low; 2-flop synchronised internally.
- rxValid  in  1  one-cycle pulse from byte slave: rx holds a complete byte.
- rx  in  8  received byte, valid with rxValid.
- tx  out  8  byte the slave shifts out next; must be stable before the next byte's first SCLK edge.
- regAddr  out  7  register address.
- regWdata  out  8  write data.
- regWe  out  1  write request, held until ack.
- regRe  out  1  read request, held until ack.
- regRdata  in  8  read data, valid with regAck.
- regAck  in  1  one-cycle completion pulse.
- busy  out  1  high while SS active or a bus request is outstanding.
- err  out  1  sticky error: overrun or timeout.

## Operation
- Command byte: bit7 = 1 read, 0 write; bits[6:0] = start address.
- States:
  - IDLE: SS inactive. Move to CMD on synchronised SS falling edge.
  - CMD: wait for a byte. Read → RD_BUS with regAddr = addr. Write → WR_DATA.
  - WR_DATA: on a byte, latch regWdata = rx, assert regWe → WR_BUS.
  - WR_BUS: on regAck, regAddr += 1 (7-bit wrap 7'h7F→7'h00) → WR_DATA.
  - RD_BUS: regRe asserted. On regAck, tx <= regRdata → RD_WAIT.
  - RD_WAIT: the next byte received is dummy (ignored). regAddr += 1 (wrap), assert regRe → RD_BUS. This prefetches the data for the following slot.
- Status byte:
  - On SS falling, tx <= {err, ID}.
  - err clears when the first byte of the frame (the command byte) is received. It does not clear if an error occurs in that same cycle.
- Overrun: rxValid in WR_BUS or RD_BUS sets err. The byte is dropped and the state is unchanged.
- Timeout: a request unacked for ACK_TIMEOUT cycles sets err. The request drops → WR_DATA (write) or RD_WAIT (read), with the address still incremented. tx keeps its old value on a read timeout.
- SS deassert:
  - In CMD, WR_DATA or RD_WAIT → IDLE immediately.
  - In WR_BUS or RD_BUS, the request is held until ack or timeout, then → IDLE. A bus handshake is never abandoned mid-request.
- rxValid in IDLE is ignored.
- tx is only updated by the status load and by read acks.

## Timing
- Reset values: tx=8'h00, regAddr=0, regWdata=0, regWe=0, regRe=0, busy=0, err=0, state IDLE.
- SS sync latency: 2 cycles. The status byte is loaded by cycle 3 after the SS pin falls.
- Request assertion: regWe/regRe rise the cycle after the rxValid that triggers them.
- Request release: regWe/regRe fall the cycle after regAck is sampled high. New requests are never issued back-to-back within that cycle.
- Read data: tx is valid the cycle after regAck.
- Master constraint: the inter-byte gap must cover 1 + bus latency + 1 cycles. Otherwise overrun is flagged.
- Timeout counter:
  - Reloads when a request is asserted.
  - Request drops on the cycle the count reaches ACK_TIMEOUT.
  - regAck on that same cycle wins: normal completion, no error.
- Simultaneous SS rise and rxValid: the byte is processed first, then the SS rule applies.
- Async reset mid-transfer: all outputs return to reset values immediately. The SS falling edge of the current frame is not detected until SS next goes high, then low.

## Test plan
- Write burst: SS low, bytes 0x05, 0x11, 0x22, ack after 3 cycles each. Expect writes addr 5=0x11 and addr 6=0x22, regWe high 4 cycles each, err=0.
- Read burst: command 0x87, regRdata 0xA0 then 0xA1. Expect regAddr 7 then 8; tx=0xA0 before byte 2 and 0xA1 before byte 3; status byte = 0x2A.
- Wrap: write command 0x7F with 2 data bytes. Expect addresses 0x7F then 0x00.
- Overrun: rxValid while regWe is pending. Expect err=1, byte dropped. The next frame's status byte = 0xAA; err clears when that frame's command byte is received.
- Timeout: ACK_TIMEOUT=4, no ack. regRe drops after 4 cycles, err=1. Next dummy byte issues a read at addr+1.
- SS rise during WR_BUS: request is held until ack, then busy=0 and state IDLE. usrReset mid-frame: all outputs read 0 immediately.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command sequencer driving a simple register bus
module spi_reg_ctrl #(
  parameter logic [6:0]  ID          = 7'h2A,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       sysClk,
  input  logic       usrReset,
  input  logic       SS,
  input  logic       rxValid,
  input  logic [7:0] rx,
  output logic [7:0] tx,
  output logic [6:0] regAddr,
  output logic [7:0] regWdata,
  output logic       regWe,
  output logic       regRe,
  input  logic [7:0] regRdata,
  input  logic       regAck,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, WR_BUS, RD_BUS, RD_WAIT} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(ACK_TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic        ss_meta;
  logic        ss_sync;
  logic        ss_prev;
  logic        ss_fall;
  logic [15:0] tmo_cnt;
  logic        timeout;
  logic        ld_status;
  logic        ld_cmd;
  logic        ld_wdata;
  logic        ld_rdata;
  logic        inc_addr;
  logic        we_set;
  logic        re_set;
  logic        req_clr;
  logic        ovr;
  logic        tmo_err;
  logic        err_clr;

  // Sync flops reset low so a frame already in progress at reset is not picked up mid-way.
  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      ss_meta <= 1'b0;
      ss_sync <= 1'b0;
      ss_prev <= 1'b0;
    end else begin
      ss_meta <= SS;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
    end
  end

  assign ss_fall = ss_prev & ~ss_sync;
  assign timeout = (tmo_cnt == TMO_LIMIT);
  assign busy    = (state != IDLE);

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_status = 1'b0;
    ld_cmd    = 1'b0;
    ld_wdata  = 1'b0;
    ld_rdata  = 1'b0;
    inc_addr  = 1'b0;
    we_set    = 1'b0;
    re_set    = 1'b0;
    req_clr   = 1'b0;
    ovr       = 1'b0;
    tmo_err   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          ld_status = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (rxValid) begin
          ld_cmd  = 1'b1;
          err_clr = 1'b1;
          if (rx[7]) begin
            re_set    = 1'b1;
            state_nxt = RD_BUS;
          end else begin
            state_nxt = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (rxValid) begin
          ld_wdata  = 1'b1;
          we_set    = 1'b1;
          state_nxt = WR_BUS;
        end
      end
      WR_BUS: begin
        ovr = rxValid;
        if (regAck || timeout) begin
          req_clr   = 1'b1;
          inc_addr  = 1'b1;
          tmo_err   = ~regAck;
          state_nxt = WR_DATA;
        end
      end
      RD_BUS: begin
        ovr = rxValid;
        if (regAck || timeout) begin
          req_clr   = 1'b1;
          ld_rdata  = regAck;
          tmo_err   = ~regAck;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rxValid) begin
          inc_addr  = 1'b1;
          re_set    = 1'b1;
          state_nxt = RD_BUS;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Bus states finish their handshake first; SS release only bites between bytes.
    if (ss_sync && (state_nxt == CMD || state_nxt == WR_DATA || state_nxt == RD_WAIT))
      state_nxt = IDLE;
  end

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      tx       <= 8'h00;
      regAddr  <= 7'h00;
      regWdata <= 8'h00;
      regWe    <= 1'b0;
      regRe    <= 1'b0;
      tmo_cnt  <= 16'd0;
      err      <= 1'b0;
    end else begin
      if (ld_status)     tx <= {err, ID};
      else if (ld_rdata) tx <= regRdata;

      if (ld_cmd)        regAddr <= rx[6:0];
      else if (inc_addr) regAddr <= regAddr + 7'd1;

      if (ld_wdata) regWdata <= rx;

      if (we_set)       regWe <= 1'b1;
      else if (req_clr) regWe <= 1'b0;

      if (re_set)       regRe <= 1'b1;
      else if (req_clr) regRe <= 1'b0;

      if (we_set || re_set)   tmo_cnt <= 16'd1;
      else if (regWe || regRe) tmo_cnt <= tmo_cnt + 16'd1;

      if (ovr || tmo_err) err <= 1'b1;
      else if (err_clr)   err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } bus_t;

  logic       sysClk = 1'b0;
  logic       usrReset;
  logic       SS;
  logic       rxValid;
  logic [7:0] rx;
  logic [7:0] tx;
  logic [6:0] regAddr;
  logic [7:0] regWdata;
  logic       regWe;
  logic       regRe;
  logic [7:0] regRdata = 8'h00;
  logic       regAck = 1'b0;
  logic       busy;
  logic       err;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   req_cyc = 0;
  int   ack_dly = 3;
  int   exp_len = 4;
  bit   ack_en = 1'b1;
  bus_t exp_q[$];
  logic [7:0] rd_q[$];

  spi_reg_ctrl #(.ID(7'h2A), .ACK_TIMEOUT(4)) dut (
    .sysClk(sysClk), .usrReset(usrReset), .SS(SS), .rxValid(rxValid), .rx(rx),
    .tx(tx), .regAddr(regAddr), .regWdata(regWdata), .regWe(regWe), .regRe(regRe),
    .regRdata(regRdata), .regAck(regAck), .busy(busy), .err(err)
  );

  always #5 sysClk = ~sysClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-bus responder: pops the scoreboard on each new request, acks after ack_dly idle cycles.
  always @(negedge sysClk) begin
    bus_t got;
    regAck = 1'b0;
    if (regWe || regRe) begin
      if (req_cyc == 0) begin
        got = {regWe, regAddr, regWe ? regWdata : 8'h00};
        check("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("req", 32'(got), 32'(exp_q.pop_front()));
      end
      req_cyc++;
      if (ack_en && req_cyc == ack_dly + 1) begin
        regAck = 1'b1;
        if (regRe) begin
          check("rdata_avail", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) regRdata = rd_q.pop_front();
        end
      end
    end else begin
      if (req_cyc != 0 && exp_len != 0) check("req_len", req_cyc, exp_len);
      req_cyc = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge sysClk);
    rxValid = 1'b1;
    rx      = b;
    @(negedge sysClk);
    rxValid = 1'b0;
    repeat (gap) @(negedge sysClk);
  endtask

  task automatic frame_start(input logic [7:0] status);
    SS = 1'b0;
    repeat (4) @(negedge sysClk);
    check("status", tx, status);
  endtask

  task automatic frame_end();
    int n;
    SS = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      @(negedge sysClk);
      n++;
    end
    check("idle", busy, 1'b0);
    repeat (4) @(negedge sysClk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    usrReset = 1'b1;
    SS       = 1'b1;
    rxValid  = 1'b0;
    rx       = 8'h00;
    repeat (3) @(negedge sysClk);
    check("rst_tx", tx, 8'h00);
    check("rst_bus", {regAddr, regWdata, regWe, regRe}, 17'h0);
    check("rst_busy_err", {busy, err}, 2'b00);
    usrReset = 1'b0;
    repeat (5) @(negedge sysClk);

    // write burst
    exp_q.push_back('{1'b1, 7'h05, 8'h11});
    exp_q.push_back('{1'b1, 7'h06, 8'h22});
    frame_start(8'h2A);
    send_byte(8'h05, 8);
    send_byte(8'h11, 8);
    send_byte(8'h22, 8);
    check("wr_err", err, 1'b0);
    check("wr_addr_next", regAddr, 7'h07);
    frame_end();

    // read burst with prefetch
    exp_q.push_back('{1'b0, 7'h07, 8'h00});
    exp_q.push_back('{1'b0, 7'h08, 8'h00});
    exp_q.push_back('{1'b0, 7'h09, 8'h00});
    rd_q.push_back(8'hA0);
    rd_q.push_back(8'hA1);
    rd_q.push_back(8'hA2);
    frame_start(8'h2A);
    send_byte(8'h87, 8);
    check("rd_tx0", tx, 8'hA0);
    send_byte(8'h00, 8);
    check("rd_tx1", tx, 8'hA1);
    send_byte(8'h00, 8);
    check("rd_tx2", tx, 8'hA2);
    frame_end();

    // address wrap
    exp_q.push_back('{1'b1, 7'h7F, 8'h33});
    exp_q.push_back('{1'b1, 7'h00, 8'h44});
    frame_start(8'h2A);
    send_byte(8'h7F, 8);
    send_byte(8'h33, 8);
    send_byte(8'h44, 8);
    check("wrap_addr", regAddr, 7'h01);
    frame_end();

    // overrun while regWe pending
    exp_q.push_back('{1'b1, 7'h10, 8'h55});
    frame_start(8'h2A);
    send_byte(8'h10, 8);
    send_byte(8'h55, 0);
    send_byte(8'h66, 8);
    check("ovr_err", err, 1'b1);
    check("ovr_wdata", regWdata, 8'h55);
    frame_end();
    exp_q.push_back('{1'b0, 7'h10, 8'h00});
    rd_q.push_back(8'h5A);
    frame_start(8'hAA);
    check("err_held", err, 1'b1);
    send_byte(8'h90, 8);
    check("err_cleared", err, 1'b0);
    check("ovr_rd_tx", tx, 8'h5A);
    frame_end();

    // read timeout
    ack_en = 1'b0;
    exp_q.push_back('{1'b0, 7'h03, 8'h00});
    frame_start(8'h2A);
    send_byte(8'h83, 8);
    check("tmo_err", err, 1'b1);
    check("tmo_tx_kept", tx, 8'h2A);
    check("tmo_re_low", regRe, 1'b0);
    ack_en = 1'b1;
    exp_q.push_back('{1'b0, 7'h04, 8'h00});
    rd_q.push_back(8'h77);
    send_byte(8'h00, 8);
    check("tmo_next_tx", tx, 8'h77);
    frame_end();

    // SS rise while write request outstanding
    exp_q.push_back('{1'b1, 7'h20, 8'h99});
    frame_start(8'hAA);
    send_byte(8'h20, 8);
    send_byte(8'h99, 0);
    SS = 1'b1;
    repeat (2) @(negedge sysClk);
    check("ssr_we_held", regWe, 1'b1);
    check("ssr_busy", busy, 1'b1);
    frame_end();
    check("ssr_we_low", regWe, 1'b0);
    check("ssr_err", err, 1'b0);

    // async reset mid-frame
    exp_q.push_back('{1'b1, 7'h40, 8'h12});
    frame_start(8'h2A);
    send_byte(8'h40, 8);
    send_byte(8'h12, 1);
    exp_len = 0;
    #2 usrReset = 1'b1;
    #1;
    check("arst_tx", tx, 8'h00);
    check("arst_bus", {regAddr, regWdata, regWe, regRe}, 17'h0);
    check("arst_busy_err", {busy, err}, 2'b00);
    @(negedge sysClk);
    usrReset = 1'b0;
    repeat (6) @(negedge sysClk);
    check("arst_no_frame", {busy, tx}, 9'h000);
    send_byte(8'h81, 8);
    check("arst_rx_ignored", regAddr, 7'h00);
    exp_len = 4;
    SS = 1'b1;
    repeat (4) @(negedge sysClk);
    frame_start(8'h2A);
    check("arst_refresh_busy", busy, 1'b1);
    frame_end();

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
